// File: rtl/instr_exec_unit.sv
// Execution stage behind the instruction register: walks a contiguous address range,
// evaluates each opcode and presents results on a valid/ready port.
module instr_exec_unit #(
    parameter int RES_W = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4:0]              start_addr,
    input  logic [5:0]              count,
    output logic [4:0]              read_pointer,
    input  logic [67:0]             instruction_word,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [RES_W-1:0] res_data,
    output logic [4:0]              res_addr,
    output logic                    res_err,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_OUT,
        S_DONE
    } state_t;

    typedef enum logic [3:0] {
        OPC_ZERO  = 4'd0,
        OPC_PASSA = 4'd1,
        OPC_PASSB = 4'd2,
        OPC_ADD   = 4'd3,
        OPC_SUB   = 4'd4,
        OPC_MULT  = 4'd5,
        OPC_DIV   = 4'd6,
        OPC_MOD   = 4'd7
    } opcode_t;

    state_t                  state;
    logic [5:0]              remaining;
    logic [3:0]              opc_q;
    logic signed [31:0]      op_a_q;
    logic signed [31:0]      op_b_q;
    logic [4:0]              addr_q;

    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] calc;
    logic                    calc_err;

    // Signed '/' and '%' truncate toward zero, so the remainder takes the dividend's sign.
    always_comb begin
        a_ext    = {{(RES_W-32){op_a_q[31]}}, op_a_q};
        b_ext    = {{(RES_W-32){op_b_q[31]}}, op_b_q};
        calc     = '0;
        calc_err = 1'b0;
        case (opc_q)
            OPC_ZERO:  calc = '0;
            OPC_PASSA: calc = a_ext;
            OPC_PASSB: calc = b_ext;
            OPC_ADD:   calc = a_ext + b_ext;
            OPC_SUB:   calc = a_ext - b_ext;
            OPC_MULT:  calc = a_ext * b_ext;
            OPC_DIV: begin
                if (b_ext == '0) calc_err = 1'b1;
                else             calc     = a_ext / b_ext;
            end
            OPC_MOD: begin
                if (b_ext == '0) calc_err = 1'b1;
                else             calc     = a_ext % b_ext;
            end
            default:   calc_err = 1'b1;
        endcase
    end

    // read_pointer doubles as the walk pointer; it only moves on start or a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            read_pointer <= '0;
            remaining    <= '0;
            opc_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            addr_q       <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_addr     <= '0;
            res_err      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= count;
                        busy      <= 1'b1;
                        if (count == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            read_pointer <= start_addr;
                            state        <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    opc_q  <= instruction_word[67:64];
                    op_a_q <= instruction_word[63:32];
                    op_b_q <= instruction_word[31:0];
                    addr_q <= read_pointer;
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    res_data  <= calc;
                    res_err   <= calc_err;
                    res_addr  <= addr_q;
                    res_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid    <= 1'b0;
                        read_pointer <= read_pointer + 5'd1;
                        remaining    <= remaining - 6'd1;
                        if (remaining == 6'd1) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Randomized bench for instr_exec_unit against a transaction-level reference model.
module tb_instr_exec_unit;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [4:0]         start_addr;
    logic [5:0]         count;
    logic [4:0]         read_pointer;
    logic [67:0]        instruction_word;
    logic               res_valid;
    logic               res_ready;
    logic signed [63:0] res_data;
    logic [4:0]         res_addr;
    logic               res_err;
    logic               busy;
    logic               done;

    logic [67:0] mem [32];
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_exec_unit #(.RES_W(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_addr         (res_addr),
        .res_err          (res_err),
        .busy             (busy),
        .done             (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [67:0] mk(input logic [3:0] o, input int a, input int b);
        return {o, a, b};
    endfunction

    // Reference: sign/magnitude division done by hand, independent of the RTL operators.
    function automatic void model(input logic [67:0] w, output logic [63:0] r, output logic e);
        longint a, b, q, m;
        longint unsigned ma, mb, mq;
        a = longint'($signed(w[63:32]));
        b = longint'($signed(w[31:0]));
        r = '0;
        e = 1'b0;
        case (w[67:64])
            4'd0: r = '0;
            4'd1: r = a;
            4'd2: r = b;
            4'd3: r = a + b;
            4'd4: r = a - b;
            4'd5: r = a * b;
            4'd6, 4'd7: begin
                if (b == 0) e = 1'b1;
                else begin
                    ma = (a < 0) ? -a : a;
                    mb = (b < 0) ? -b : b;
                    mq = ma / mb;
                    q  = ((a < 0) != (b < 0)) ? -longint'(mq) : longint'(mq);
                    m  = (a < 0) ? -longint'(ma - mq * mb) : longint'(ma - mq * mb);
                    r  = (w[67:64] == 4'd6) ? q : m;
                end
            end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            mem[i] = mk(4'($urandom_range(0, 15)), int'($urandom),
                        ($urandom_range(0, 5) == 0) ? 0 : int'($urandom));
        end
    endtask

    // Starts a run at the current negedge and follows it to completion, sampling on negedges.
    task automatic run(input logic [4:0] sa, input logic [5:0] cnt, input int unsigned stall,
                       input bit rnd, input bit poke);
        logic [4:0]  exp_addr;
        int unsigned got, dones, cyc, last_hs, done_cyc, stall_left;
        bit          prev_hold, prev_v;
        logic [63:0] h_data, m_data;
        logic [4:0]  h_addr, h_rp;
        logic        h_err, m_err;
        exp_addr = sa; got = 0; dones = 0; last_hs = 0; done_cyc = 0;
        stall_left = stall; prev_hold = 0; prev_v = 0;
        h_data = '0; h_addr = '0; h_rp = '0; h_err = 1'b0;
        start = 1'b1; start_addr = sa; count = cnt; res_ready = (stall == 0);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("busy_rise", 64'(busy), 64'(1));
        forever begin
            if (poke && cyc == 2) begin
                start = 1'b1; start_addr = sa + 5'd9; count = 6'd2;
            end else if (poke && cyc == 3) begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (prev_hold) begin
                check("hold_valid", 64'(res_valid), 64'(1));
                check("hold_data", res_data, h_data);
                check("hold_addr", 64'(res_addr), 64'(h_addr));
                check("hold_err", 64'(res_err), 64'(h_err));
                check("hold_rp", 64'(read_pointer), 64'(h_rp));
            end
            prev_hold = 0;
            if (res_valid) begin
                if (!prev_v) begin
                    if (got == 0) check("first_latency", 64'(cyc), 64'(3));
                    else          check("next_latency", 64'(cyc - last_hs), 64'(3));
                end
                check("rp_during_valid", 64'(read_pointer), 64'(exp_addr));
                if (rnd)                 res_ready = 1'($urandom_range(0, 1));
                else if (stall_left > 0) begin res_ready = 1'b0; stall_left--; end
                else                     res_ready = 1'b1;
                if (res_ready) begin
                    model(mem[exp_addr], m_data, m_err);
                    check("res_data", res_data, m_data);
                    check("res_addr", 64'(res_addr), 64'(exp_addr));
                    check("res_err", 64'(res_err), 64'(m_err));
                    got++;
                    exp_addr = exp_addr + 5'd1;
                    last_hs = cyc;
                end else begin
                    prev_hold = 1;
                    h_data = res_data; h_addr = res_addr; h_err = res_err; h_rp = read_pointer;
                end
            end
            prev_v = res_valid;
            if (dones > 0 && cyc == done_cyc + 1) begin
                check("busy_fall", 64'(busy), 64'(0));
                check("done_single", 64'(done), 64'(0));
                break;
            end
            if (cyc >= 400) begin
                check("run_timeout", 64'(dones), 64'(1));
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("result_count", 64'(got), 64'(cnt));
        check("done_count", 64'(dones), 64'(1));
        if (cnt == 0) check("done_zero_latency", 64'(done_cyc), 64'(1));
        else          check("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rp"}, 64'(read_pointer), 64'(0));
        check({tag, "_valid"}, 64'(res_valid), 64'(0));
        check({tag, "_data"}, res_data, 64'(0));
        check({tag, "_addr"}, 64'(res_addr), 64'(0));
        check({tag, "_err"}, 64'(res_err), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        int unsigned n;
        fill_random();
        reset = 1'b1;
        start = 1'($urandom_range(0, 1));
        start_addr = 5'($urandom);
        count = 6'($urandom_range(0, 32));
        res_ready = 1'($urandom_range(0, 1));
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);

        mem[0] = mk(4'd3, 5, 7);
        mem[1] = mk(4'd4, 3, 10);
        mem[2] = mk(4'd5, -4, 6);
        run(5'd0, 6'd3, 0, 0, 0);
        run(5'd0, 6'd3, 5, 0, 0);

        mem[30] = mk(4'd1, 30, 0);
        mem[31] = mk(4'd2, 0, 31);
        mem[0]  = mk(4'd3, -1, 1);
        mem[1]  = mk(4'd0, 9, 9);
        run(5'd30, 6'd4, 0, 0, 0);

        mem[0] = mk(4'd6, -7, 2);
        mem[1] = mk(4'd7, -7, 2);
        mem[2] = mk(4'd6, 5, 0);
        mem[3] = mk(4'd6, 32'sh8000_0000, -1);
        mem[4] = mk(4'd12, 3, 4);
        mem[5] = mk(4'd7, 7, -2);
        mem[6] = mk(4'd7, 5, 0);
        mem[7] = mk(4'd5, 32'sh8000_0000, 32'sh8000_0000);
        run(5'd0, 6'd8, 0, 0, 0);

        run(5'd5, 6'd0, 0, 0, 0);
        run(5'd10, 6'd3, 0, 0, 1);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run(5'($urandom), 6'($urandom_range(1, 32)), 0, 1, 0);
        end

        // Reset while a result is held in OUT.
        fill_random();
        start = 1'b1; start_addr = 5'd3; count = 6'd3; res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!res_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("midrun_valid_seen", 64'(res_valid), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midrun_reset");
        reset = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_done", 64'(done), 64'(0));
            check("post_reset_valid", 64'(res_valid), 64'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
